scan_rate_gen: RTL and testbench



---
 rtl/scan_rate_pkg.sv | 46 ++++
 rtl/key_debounce.sv | 61 ++++++
 rtl/scan_rate_gen.sv | 149 ++++++++++++++
 tb/tb_scan_rate_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_rate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_rate_pkg
//  Description : Shared types and helpers for the scan-rate pacing stage:
//                run/pause state encoding, width helpers and the
//                shift-based tick-period function.
//  Revision    : 1.0  initial release
// ============================================================================
package scan_rate_pkg;

    // Run-state encoding for the pacing FSM.
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } run_state_t;

    // Key positions inside the packed key/event vectors of the top level.
    localparam int c_key_faster = 0;
    localparam int c_key_slower = 1;
    localparam int c_key_pause  = 2;
    localparam int c_key_step   = 3;
    localparam int c_num_keys   = 4;

    // Divider count width: must hold 0..BASE_DIV-1.
    function automatic int count_width(input int unsigned base);
        return (base > 1) ? $clog2(base) : 1;
    endfunction

    // Speed-level width: must hold 0..NUM_LEVELS-1.
    function automatic int level_width(input int unsigned levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

    // Tick period at a given level. Each level doubles the rate, so the
    // period is a plain right shift of the base divider.
    function automatic int unsigned tick_period(input int unsigned base,
                                                input int unsigned level);
        return base >> level;
    endfunction

    // Default widths for the board build (50 MHz, 8 levels).
    localparam int c_cnt_w_default = count_width(25000000);
    localparam int c_lvl_w_default = level_width(8);

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Raw active-low pushbutton conditioner. Two-flop
//                synchronizer, stability counter, debounced key state and a
//                one-cycle press event on each accepted release->press edge.
//  Ports       : clock     - system clock, rising edge
//                reset_n   - asynchronous active-low reset
//                key_n     - raw pushbutton, low = pressed
//                press_evt - one-cycle pulse when a press is accepted
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic press_evt
);

    localparam int                  c_dcnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample on which the counter would reach DEBOUNCE_CYCLES is the
    // one that commits the new level.
    localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(DEBOUNCE_CYCLES - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_stable;
    logic                r_evt;
    logic [c_dcnt_w-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_evt    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_evt   <= 1'b0;
            if (r_sync2 == r_stable) begin
                // Any bounce back to the committed level restarts the window.
                r_cnt <= '0;
            end else if (r_cnt == c_dcnt_last) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
                // Only the 1->0 commit is a press; releases are silent.
                r_evt    <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + c_dcnt_w'(1);
            end
        end
    end

    assign press_evt = r_evt;

endmodule
`default_nettype wire

// File: rtl/scan_rate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : scan_rate_gen
//  Description : Pacing stage for the bouncing LED scan. Divides the board
//                clock into a one-cycle tick at one of NUM_LEVELS rates,
//                controlled by four debounced pushbuttons.
//  Ports       : clock        - system clock, rising edge
//                reset_n      - asynchronous active-low reset
//                key_faster_n - raw key, raise speed level
//                key_slower_n - raw key, lower speed level
//                key_pause_n  - raw key, toggle run/pause
//                key_step_n   - raw key, single tick while paused
//                tick         - registered one-cycle enable to the scanner
//                speed_level  - current level, 0 = slowest
//                running      - 1 = running, 0 = paused
//  Revision    : 1.0  initial release
// ============================================================================
module scan_rate_gen
    import scan_rate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BASE_DIV        = 25000000,
    // NUM_LEVELS must not exceed log2(BASE_DIV) so the slowest-to-fastest
    // shift never drives the period to zero.
    parameter int NUM_LEVELS      = 8,
    parameter int DEFAULT_LEVEL   = 3
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               key_faster_n,
    input  logic                               key_slower_n,
    input  logic                               key_pause_n,
    input  logic                               key_step_n,
    output logic                               tick,
    output logic [level_width(NUM_LEVELS)-1:0] speed_level,
    output logic                               running
);

    localparam int                 c_cnt_w   = count_width(BASE_DIV);
    localparam int                 c_lvl_w   = level_width(NUM_LEVELS);
    localparam logic [c_lvl_w-1:0] c_lvl_max = c_lvl_w'(NUM_LEVELS - 1);
    localparam logic [c_lvl_w-1:0] c_lvl_def = c_lvl_w'(DEFAULT_LEVEL);

    // ------------------------------------------------------------------
    // Key conditioning
    // ------------------------------------------------------------------
    logic [c_num_keys-1:0] w_keys_n;
    logic [c_num_keys-1:0] w_evt;

    assign w_keys_n[c_key_faster] = key_faster_n;
    assign w_keys_n[c_key_slower] = key_slower_n;
    assign w_keys_n[c_key_pause]  = key_pause_n;
    assign w_keys_n[c_key_step]   = key_step_n;

    for (genvar gi = 0; gi < c_num_keys; gi++) begin : g_keys
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clock     (clock),
            .reset_n   (reset_n),
            .key_n     (w_keys_n[gi]),
            .press_evt (w_evt[gi])
        );
    end

    logic w_faster;
    logic w_slower;
    logic w_pause;
    logic w_step;

    assign w_faster = w_evt[c_key_faster];
    assign w_slower = w_evt[c_key_slower];
    assign w_pause  = w_evt[c_key_pause];
    assign w_step   = w_evt[c_key_step];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    run_state_t         r_state;
    logic [c_lvl_w-1:0] r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tick;

    run_state_t         w_state_nxt;
    logic [c_lvl_w-1:0] w_level_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_tick_nxt;
    logic [c_cnt_w-1:0] w_last_cur;
    logic [c_cnt_w-1:0] w_last_nxt;

    // Terminal count (P-1) for the current and the upcoming level.
    assign w_last_cur = c_cnt_w'(tick_period(BASE_DIV, 32'(r_level)) - 1);
    assign w_last_nxt = c_cnt_w'(tick_period(BASE_DIV, 32'(w_level_nxt)) - 1);

    always_comb begin
        w_level_nxt = r_level;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tick_nxt  = 1'b0;

        // Simultaneous faster+slower cancel out.
        if (w_faster && !w_slower && (r_level != c_lvl_max)) begin
            w_level_nxt = r_level + c_lvl_w'(1);
        end else if (w_slower && !w_faster && (r_level != '0)) begin
            w_level_nxt = r_level - c_lvl_w'(1);
        end

        if (w_pause) begin
            w_state_nxt = (r_state == RUN) ? PAUSED : RUN;
        end

        // A real level change restarts the period so the new rate takes
        // effect cleanly; a saturated request leaves the phase alone.
        if (w_level_nxt != r_level) begin
            w_cnt_nxt = '0;
        end else if (r_state == RUN) begin
            w_cnt_nxt = (r_cnt == w_last_cur) ? '0 : r_cnt + c_cnt_w'(1);
        end

        // tick is registered, so it is decided from the values the counter
        // and FSM will hold after this edge. A count parked at P-1 while
        // paused therefore ticks on the first running cycle.
        if (w_state_nxt == RUN) begin
            w_tick_nxt = (w_cnt_nxt == w_last_nxt);
        end else begin
            w_tick_nxt = w_step && (r_state == PAUSED);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_level <= c_lvl_def;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    assign tick        = r_tick;
    assign speed_level = r_level;
    assign running     = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_scan_rate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_rate_gen
//  Description : Directed self-checking bench for scan_rate_gen with
//                DEBOUNCE_CYCLES=4, BASE_DIV=64, NUM_LEVELS=4,
//                DEFAULT_LEVEL=1 (periods 64/32/16/8 by level).
//                Key timing: a key driven low just before edge E1 is
//                committed at E6 and acted on at E7.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scan_rate_gen;

    localparam int c_deb    = 4;
    localparam int c_base   = 64;
    localparam int c_levels = 4;
    localparam int c_def    = 1;

    localparam logic [3:0] c_m_faster = 4'b0001;
    localparam logic [3:0] c_m_slower = 4'b0010;
    localparam logic [3:0] c_m_pause  = 4'b0100;
    localparam logic [3:0] c_m_step   = 4'b1000;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] keys_n;
    logic       tick;
    logic [1:0] speed_level;
    logic       running;

    int n_checks = 0;
    int n_pass   = 0;
    int n;
    int nticks;
    int first;

    scan_rate_gen #(
        .DEBOUNCE_CYCLES (c_deb),
        .BASE_DIV        (c_base),
        .NUM_LEVELS      (c_levels),
        .DEFAULT_LEVEL   (c_def)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .key_faster_n (keys_n[0]),
        .key_slower_n (keys_n[1]),
        .key_pause_n  (keys_n[2]),
        .key_step_n   (keys_n[3]),
        .tick         (tick),
        .speed_level  (speed_level),
        .running      (running)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Advance edge by edge until tick is seen; n = edges taken.
    task automatic wait_tick(input string tag, input int maxc, output int cnt);
        cnt = 0;
        do begin
            @(posedge clock);
            #1;
            cnt++;
        end while (tick !== 1'b1 && cnt < maxc);
        n_checks++;
        assert (tick === 1'b1) n_pass++;
        else $error("FAIL %s: no tick within %0d cycles, observed %b, expected 1", tag, maxc, tick);
    endtask

    // Drive the masked keys low before edge E1, release them before edge
    // E(hold+1), and watch 24 edges; ticks are sampled on negedges.
    task automatic press(input logic [3:0] mask, input int hold,
                         output int cnt, output int first_k);
        cnt     = 0;
        first_k = 0;
        @(negedge clock);
        keys_n = keys_n & ~mask;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock);
            if (k == hold) keys_n = keys_n | mask;
            if (tick === 1'b1) begin
                cnt++;
                if (first_k == 0) first_k = k;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        keys_n  = 4'hF;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_tick",    32'(tick),        32'd0);
        check("rst_level",   32'(speed_level), 32'd1);
        check("rst_running", 32'(running),     32'd1);

        // Free run at level 1 (period 32)
        @(negedge clock);
        reset_n = 1'b1;
        wait_tick("first_tick_wait", 100, n);
        check("first_tick_edge", 32'(n), 32'd31);
        for (int i = 0; i < 9; i++) begin
            wait_tick("period_l1_wait", 100, n);
            check("period_l1", 32'(n), 32'd32);
        end

        // Faster: level 2, count cleared at E7, tick at count 15 -> E22
        press(c_m_faster, 10, nticks, first);
        check("faster_level", 32'(speed_level), 32'd2);
        check("faster_ticks", 32'(nticks),      32'd1);
        check("faster_first", 32'(first),       32'd22);
        wait_tick("period_l2_wait", 100, n);
        check("period_l2_a", 32'(n), 32'd14);
        wait_tick("period_l2_wait", 100, n);
        check("period_l2_b", 32'(n), 32'd16);

        // Three more faster presses: 3, then saturated
        for (int i = 0; i < 3; i++) begin
            press(c_m_faster, 10, nticks, first);
            check("faster_sat_level", 32'(speed_level), 32'd3);
        end
        wait_tick("sync_l3", 100, n);
        wait_tick("period_l3_wait", 100, n);
        check("period_l3_a", 32'(n), 32'd8);
        wait_tick("period_l3_wait", 100, n);
        check("period_l3_b", 32'(n), 32'd8);

        // Three-cycle glitch on slower: rejected, cadence untouched
        press(c_m_slower, 3, nticks, first);
        check("glitch_level", 32'(speed_level), 32'd3);
        check("glitch_ticks", 32'(nticks),      32'd3);
        check("glitch_first", 32'(first),       32'd8);

        // Pause: counter stops at 6, no ticks
        wait_tick("pause_sync_wait", 100, n);
        check("pause_sync", 32'(n), 32'd8);
        press(c_m_pause, 10, nticks, first);
        check("pause_running", 32'(running), 32'd0);
        check("pause_ticks",   32'(nticks),  32'd0);
        nticks = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #1;
            if (tick === 1'b1) nticks++;
        end
        check("paused_200_ticks", 32'(nticks), 32'd0);

        // Two single steps
        for (int i = 0; i < 2; i++) begin
            press(c_m_step, 10, nticks, first);
            check("step_ticks", 32'(nticks), 32'd1);
            check("step_first", 32'(first),  32'd7);
        end

        // Resume from held count 6: ticks at E8, E16, E24
        press(c_m_pause, 10, nticks, first);
        check("resume_running", 32'(running), 32'd1);
        check("resume_first",   32'(first),   32'd8);
        check("resume_ticks",   32'(nticks),  32'd3);

        // Slower: back to level 2, count cleared at E7 -> tick E22
        wait_tick("slower_sync_wait", 100, n);
        check("slower_sync", 32'(n), 32'd8);
        press(c_m_slower, 10, nticks, first);
        check("slower_level", 32'(speed_level), 32'd2);
        check("slower_first", 32'(first),       32'd22);

        // Faster+slower together: no level change, count not cleared
        wait_tick("both_sync_wait", 100, n);
        check("both_sync", 32'(n), 32'd14);
        press(c_m_faster | c_m_slower, 10, nticks, first);
        check("both_level", 32'(speed_level), 32'd2);
        check("both_first", 32'(first),       32'd16);
        check("both_ticks", 32'(nticks),      32'd1);

        // Level 3, paused, then reset mid-step-tick
        press(c_m_faster, 10, nticks, first);
        check("pre_rst_level", 32'(speed_level), 32'd3);
        press(c_m_pause, 10, nticks, first);
        check("pre_rst_running", 32'(running), 32'd0);
        @(negedge clock);
        keys_n[3] = 1'b0;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (tick !== 1'b1 && n < 20);
        check("pre_rst_step_tick", 32'(tick), 32'd1);
        check("pre_rst_step_edge", 32'(n),    32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_tick",    32'(tick),        32'd0);
        check("async_rst_running", 32'(running),     32'd1);
        check("async_rst_level",   32'(speed_level), 32'd1);
        keys_n = 4'hF;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wait_tick("post_rst_wait", 100, n);
        check("post_rst_first", 32'(n), 32'd31);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
